// File: rtl/pool_stream.sv
// pool_stream: streams the pooled feature-map BRAM out as a flattened activation vector
// in CHW or HWC order; a credit-limited FIFO absorbs read latency and back-pressure.
module pool_stream #(
   parameter int DATA_WIDTH = 16,
   parameter int CHANNELS   = 8,
   parameter int OUT_SIZE   = 14,
   parameter int BRAM_LAT   = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int HWC_ORDER  = 0,
   localparam int N  = CHANNELS * OUT_SIZE * OUT_SIZE,
   localparam int AW = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [AW-1:0]         pool_addr,
   output logic                  pool_en,
   input  logic [DATA_WIDTH-1:0] pool_q,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done
);
   localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int SW    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CNTW  = $clog2(FIFO_DEPTH + 1);
   localparam int PLANE = OUT_SIZE * OUT_SIZE;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;
   state_t state, next_state;

   logic [AW-1:0]   idx, idx_b, idx_n, cur_addr, hwc_addr;
   logic [CW-1:0]   c, c_b, c_n;
   logic [SW-1:0]   q, q_b, q_n, r, r_b, r_n;
   logic            issue, pop, push, is_last, pool_last;
   logic [BRAM_LAT-1:0] pipe_v, pipe_l;
   logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CNTW-1:0] fifo_count, credit_used;

   assign m_valid = (fifo_count != '0);
   assign m_data  = mem[rd_ptr][DATA_WIDTH-1:0];
   assign m_last  = mem[rd_ptr][DATA_WIDTH];
   assign pop     = m_valid && m_ready;
   assign push    = pipe_v[BRAM_LAT-1];

   // Next state, read issue and address-counter advance
   always_comb begin
      next_state = state;
      issue      = 1'b0;
      if (state == IDLE) begin
         idx_b = '0; c_b = '0; q_b = '0; r_b = '0;
      end else begin
         idx_b = idx; c_b = c; q_b = q; r_b = r;
      end
      is_last  = (idx_b == AW'(N - 1));
      hwc_addr = AW'(int'(c_b) * PLANE + int'(r_b) * OUT_SIZE + int'(q_b));
      cur_addr = (HWC_ORDER != 0) ? hwc_addr : idx_b;
      idx_n    = idx_b + AW'(1);
      q_n      = q_b;
      r_n      = r_b;
      if (c_b == CW'(CHANNELS - 1)) begin
         c_n = '0;
         if (q_b == SW'(OUT_SIZE - 1)) begin
            q_n = '0;
            r_n = r_b + SW'(1);
         end else begin
            q_n = q_b + SW'(1);
         end
      end else begin
         c_n = c_b + CW'(1);
      end
      // credit counts the read on the bus, reads in the BRAM pipe and FIFO entries
      case (state)
         IDLE: begin
            if (start) begin
               issue      = 1'b1;
               next_state = is_last ? DRAIN : RUN;
            end else begin
               next_state = IDLE;
            end
         end
         RUN: begin
            if ((credit_used != CNTW'(FIFO_DEPTH)) || pop) begin
               issue      = 1'b1;
               next_state = is_last ? DRAIN : RUN;
            end else begin
               next_state = RUN;
            end
         end
         DRAIN: begin
            if (pop && (credit_used == CNTW'(1))) next_state = FINISH;
            else                                  next_state = DRAIN;
         end
         FINISH:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // Read port, address counters, credit and status flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pool_en <= 1'b0; pool_last <= 1'b0; pool_addr <= '0;
         idx <= '0; c <= '0; q <= '0; r <= '0;
         busy <= 1'b0; done <= 1'b0; credit_used <= '0;
      end else begin
         pool_en   <= issue;
         pool_last <= issue && is_last;
         busy      <= (next_state != IDLE);
         done      <= (next_state == FINISH);
         if (issue) begin
            pool_addr <= cur_addr;
            idx <= idx_n; c <= c_n; q <= q_n; r <= r_n;
         end else begin
            idx <= idx_b; c <= c_b; q <= q_b; r <= r_b;
         end
         case ({issue, pop})
            2'b10:   credit_used <= credit_used + CNTW'(1);
            2'b01:   credit_used <= credit_used - CNTW'(1);
            default: credit_used <= credit_used;
         endcase
      end
   end

   // BRAM latency tracker: valid and last flag travel with each read
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pipe_v <= '0;
         pipe_l <= '0;
      end else begin
         pipe_v[0] <= pool_en;
         pipe_l[0] <= pool_last;
         for (int i = 1; i < BRAM_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_l[i] <= pipe_l[i-1];
         end
      end
   end

   // Output FIFO
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0; rd_ptr <= '0; fifo_count <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {pipe_l[BRAM_LAT-1], pool_q};
            wr_ptr      <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end else begin
            wr_ptr <= wr_ptr;
         end
         if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         else     rd_ptr <= rd_ptr;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNTW'(1);
            2'b01:   fifo_count <= fifo_count - CNTW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   pool_stream_chk #(.FIFO_DEPTH(FIFO_DEPTH), .CNTW(CNTW)) u_chk (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .fifo_count(fifo_count)
   );
endmodule

// pool_stream_chk: the credit rule must make a FIFO overflow impossible.
module pool_stream_chk #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNTW       = 3
) (
   input logic            clk,
   input logic            reset,
   input logic            push,
   input logic            pop,
   input logic [CNTW-1:0] fifo_count
);
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(push && !pop && (fifo_count == CNTW'(FIFO_DEPTH))))
      else $error("pool_stream FIFO overflow");
endmodule
